// File: rtl/wb_port_arbiter.sv
// Writeback arbiter for the register-file write port: ALU results take priority,
// long-latency results queue in a small FIFO and drain when the ALU leaves the port free.
module wb_port_arbiter #(
  parameter int bit_size     = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [4:0]          alu_addr,
  input  logic [bit_size-1:0] alu_data,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [4:0]          lu_addr,
  input  logic [bit_size-1:0] lu_data,
  output logic                RegWrite,
  output logic [4:0]          Write_addr,
  output logic [bit_size-1:0] Write_data,
  output logic [31:0]         pending_mask,
  output logic                stall_req
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]          addr_q [DEPTH];
  logic [bit_size-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [WAIT_W-1:0]   wait_cnt;

  logic full, empty, alu_win, push, pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign lu_ready = !full;
  // A $0 long-latency result completes its handshake but is dropped here.
  assign push     = lu_valid && !full && (lu_addr != 5'd0);
  assign alu_win  = alu_valid && (alu_addr != 5'd0);
  assign pop      = !alu_win && !empty;
  assign stall_req = (wait_cnt == WAIT_W'(STARVE_LIMIT));

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count)
        pending_mask[addr_q[i]] = 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset; liveness comes from count/pointers, so
  // stale contents are never observed and the arrays can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= lu_addr;
      data_q[wr_ptr] <= lu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      if (empty || pop)      wait_cnt <= '0;
      else if (!stall_req)   wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite   <= 1'b0;
      Write_addr <= '0;
      Write_data <= '0;
    end else if (alu_win) begin
      RegWrite   <= 1'b1;
      Write_addr <= alu_addr;
      Write_data <= alu_data;
    end else if (pop) begin
      RegWrite   <= 1'b1;
      Write_addr <= addr_q[rd_ptr];
      Write_data <= data_q[rd_ptr];
    end else begin
      // Address and data hold so an idle port does not toggle the write bus.
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a queue model of the FIFO predicts each
// write, expected writes go through a scoreboard queue and are checked on output.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lu_valid, lu_ready;
  logic [4:0]  alu_addr, lu_addr;
  logic [31:0] alu_data, lu_data;
  logic        RegWrite;
  logic [4:0]  Write_addr;
  logic [31:0] Write_data;
  logic [31:0] pending_mask;
  logic        stall_req;

  int errors = 0;
  int checks = 0;

  wr_t model_q[$];
  wr_t exp_q[$];

  wb_port_arbiter #(.bit_size(32), .DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .RegWrite(RegWrite), .Write_addr(Write_addr), .Write_data(Write_data),
    .pending_mask(pending_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lu_valid  = lv; lu_addr  = la; lu_data  = ld;
  endtask

  // One clock: predict from current inputs, advance, then compare outputs.
  task automatic step(input string tag);
    logic  exp_we;
    logic  ready;
    wr_t   w;
    logic [31:0] mask;
    ready = (model_q.size() < DEPTH);
    check({tag, ".lu_ready"}, lu_ready, ready);
    exp_we = 1'b1;
    if (alu_valid && alu_addr != 5'd0) begin
      w.addr = alu_addr; w.data = alu_data; exp_q.push_back(w);
    end else if (model_q.size() > 0) begin
      exp_q.push_back(model_q.pop_front());
    end else begin
      exp_we = 1'b0;
    end
    if (lu_valid && ready && lu_addr != 5'd0) begin
      w.addr = lu_addr; w.data = lu_data; model_q.push_back(w);
    end
    @(posedge clk);
    #1;
    check({tag, ".RegWrite"}, RegWrite, exp_we);
    if (RegWrite && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, ".Write_addr"}, Write_addr, w.addr);
      check({tag, ".Write_data"}, Write_data, w.data);
    end
    mask = '0;
    foreach (model_q[i]) mask[model_q[i].addr] = 1'b1;
    check({tag, ".pending_mask"}, pending_mask, mask);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".RegWrite"}, RegWrite, 1'b0);
    check({tag, ".Write_addr"}, Write_addr, 5'd0);
    check({tag, ".Write_data"}, Write_data, 32'd0);
    check({tag, ".pending_mask"}, pending_mask, 32'd0);
    check({tag, ".lu_ready"}, lu_ready, 1'b1);
    check({tag, ".stall_req"}, stall_req, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    check_reset_state("reset");
    #10 rst = 1'b1;

    // Single ALU write, then idle.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    step("alu_single");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("alu_idle");

    // Priority: lu r7 queued while ALU writes r3 three times.
    drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd7, 32'hAA);
    step("prio0");
    check("prio0.mask_r7", pending_mask, 32'h80);
    drive(1'b1, 5'd3, 32'h32, 1'b0, 5'd0, 32'd0);
    step("prio1");
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    step("prio2");
    check("prio2.mask_r7", pending_mask, 32'h80);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("prio_drain");
    check("prio_drain.addr", Write_addr, 5'd7);
    step("prio_idle");

    // Full / backpressure: four pushes with the ALU busy, a fifth refused.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'hB00 + 32'(i));
      step("fill");
    end
    check("full.lu_ready", lu_ready, 1'b0);
    drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd14, 32'hBEEF);
    step("fifth_refused");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("drain0");
    check("after_pop.lu_ready", lu_ready, 1'b1);
    for (int i = 1; i < 5; i++) step("drain");

    // $0 filtering on both sources.
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF);
    step("zero_both");
    check("zero_both.mask", pending_mask, 32'd0);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
    step("zero_push_r9");
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    step("zero_drains_r9");
    check("zero_drains_r9.addr", Write_addr, 5'd9);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("zero_idle");

    // Starvation: r4 waits behind a continuous ALU stream.
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd4, 32'h44);
    step("starve_push");
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'd1, 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
      step("starve_wait");
      check("starve_wait.stall_req", stall_req, (i == 8));
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("starve_release");
    check("starve_release.addr", Write_addr, 5'd4);
    check("starve_release.stall_req", stall_req, 1'b0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 32'h200, 1'b1, 5'(20 + i), 32'hC0 + 32'(i));
      step("pre_reset_fill");
    end
    #3 rst = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_q.delete();
    exp_q.delete();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2 rst = 1'b1;
    step("post_reset0");
    step("post_reset1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
